// File: rtl/control_sequencer.sv
// control_sequencer
//   Timing-sequence counter (SC, T0..T7) and hardwired control unit for the
//   8-bit accumulator CPU. Drives the BUS multiplexer select and the
//   load/increment/clear/memory strobes for AR, PC, DR, AC, IR and memory.
//
// Ports
//   clk       in  1  rising-edge clock
//   reset     in  1  synchronous, active-high
//   enable    in  1  low: SC/halted hold, every control output deasserted
//   IR_DATA   in  8  {I, opcode[2:0], reg-ref micro-ops[3:0]}
//   dr_zero   in  1  DR == 0, used only in ISZ T7
//   bus_sel   out 3  000 X, 001 AR, 010 PC, 011 DR, 100 AC, 101 IR, 110 TR, 111 MEM
//   ar_ld, ar_inc, pc_ld, pc_inc, dr_ld, dr_inc   out 1  register strobes
//   ac_ld, ac_clr, ac_inc                         out 1  AC controls
//   alu_op    out 2  00 AND, 01 ADD, 10 PASS DR, 11 NOT AC (00 unless ac_ld)
//   ir_ld     out 1  load IR from bus
//   mem_rd    out 1  memory read strobe
//   mem_wr    out 1  memory write of bus value at address AR
//   sc        out 3  current T-state
//   halted    out 1  HLT executed; cleared only by reset
module control_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] IR_DATA,
  input  logic       dr_zero,
  output logic [2:0] bus_sel,
  output logic       ar_ld,
  output logic       ar_inc,
  output logic       pc_ld,
  output logic       pc_inc,
  output logic       dr_ld,
  output logic       dr_inc,
  output logic       ac_ld,
  output logic       ac_clr,
  output logic       ac_inc,
  output logic [1:0] alu_op,
  output logic       ir_ld,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic [2:0] sc,
  output logic       halted
);

  // T-states
  localparam logic [2:0] T0 = 3'd0;
  localparam logic [2:0] T1 = 3'd1;
  localparam logic [2:0] T2 = 3'd2;
  localparam logic [2:0] T3 = 3'd3;
  localparam logic [2:0] T4 = 3'd4;
  localparam logic [2:0] T5 = 3'd5;
  localparam logic [2:0] T6 = 3'd6;
  localparam logic [2:0] T7 = 3'd7;

  // Bus sources
  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_AR   = 3'b001;
  localparam logic [2:0] SEL_PC   = 3'b010;
  localparam logic [2:0] SEL_DR   = 3'b011;
  localparam logic [2:0] SEL_AC   = 3'b100;
  localparam logic [2:0] SEL_MEM  = 3'b111;

  // Opcodes
  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_LDA  = 3'b010;
  localparam logic [2:0] OP_STA  = 3'b011;
  localparam logic [2:0] OP_BUN  = 3'b100;
  localparam logic [2:0] OP_BSA  = 3'b101;
  localparam logic [2:0] OP_ISZ  = 3'b110;
  localparam logic [2:0] OP_RREF = 3'b111;

  // ALU functions
  localparam logic [1:0] ALU_AND  = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_PASS = 2'b10;
  localparam logic [1:0] ALU_NOT  = 2'b11;

  logic [2:0] sc_q, sc_d;
  logic       halted_q, halted_d;

  logic       ind;
  logic [2:0] opcode;
  logic       cla, cma, inc, hlt;
  logic       active;

  assign ind    = IR_DATA[7];
  assign opcode = IR_DATA[6:4];
  assign cla    = IR_DATA[3];
  assign cma    = IR_DATA[2];
  assign inc    = IR_DATA[1];
  assign hlt    = IR_DATA[0];

  // Reset is folded into the decode gate so strobes are quiet during the
  // reset cycle itself, not only after the edge.
  assign active = enable && !halted_q && !reset;

  always_comb begin
    bus_sel  = SEL_NONE;
    ar_ld    = 1'b0;
    ar_inc   = 1'b0;
    pc_ld    = 1'b0;
    pc_inc   = 1'b0;
    dr_ld    = 1'b0;
    dr_inc   = 1'b0;
    ac_ld    = 1'b0;
    ac_clr   = 1'b0;
    ac_inc   = 1'b0;
    alu_op   = ALU_AND;
    ir_ld    = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    sc_d     = sc_q;
    halted_d = halted_q;

    if (active) begin
      sc_d = sc_q + 3'd1;
      case (sc_q)
        T0: begin
          bus_sel = SEL_PC;
          ar_ld   = 1'b1;
        end
        T1: begin
          bus_sel = SEL_MEM;
          mem_rd  = 1'b1;
          ir_ld   = 1'b1;
          pc_inc  = 1'b1;
        end
        T2: begin
          if (opcode == OP_RREF) begin
            sc_d = T0;
            // I=1 with opcode 111 is a NOP
            if (!ind) begin
              if (cla) begin
                ac_clr = 1'b1;
              end else if (cma) begin
                ac_ld  = 1'b1;
                alu_op = ALU_NOT;
              end else if (inc) begin
                ac_inc = 1'b1;
              end
              if (hlt) halted_d = 1'b1;
            end
          end else begin
            bus_sel = SEL_PC;
            ar_ld   = 1'b1;
          end
        end
        T3: begin
          bus_sel = SEL_MEM;
          mem_rd  = 1'b1;
          ar_ld   = 1'b1;
          pc_inc  = 1'b1;
        end
        T4: begin
          // Slot is always consumed so direct and indirect take equal time
          if (ind) begin
            bus_sel = SEL_MEM;
            mem_rd  = 1'b1;
            ar_ld   = 1'b1;
          end
        end
        T5: begin
          case (opcode)
            OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
              bus_sel = SEL_MEM;
              mem_rd  = 1'b1;
              dr_ld   = 1'b1;
            end
            OP_STA: begin
              bus_sel = SEL_AC;
              mem_wr  = 1'b1;
              sc_d    = T0;
            end
            OP_BUN: begin
              bus_sel = SEL_AR;
              pc_ld   = 1'b1;
              sc_d    = T0;
            end
            OP_BSA: begin
              bus_sel = SEL_PC;
              mem_wr  = 1'b1;
              ar_inc  = 1'b1;
            end
            default: sc_d = T0;
          endcase
        end
        T6: begin
          sc_d = T0;
          case (opcode)
            OP_AND: begin
              ac_ld  = 1'b1;
              alu_op = ALU_AND;
            end
            OP_ADD: begin
              ac_ld  = 1'b1;
              alu_op = ALU_ADD;
            end
            OP_LDA: begin
              ac_ld  = 1'b1;
              alu_op = ALU_PASS;
            end
            OP_BSA: begin
              bus_sel = SEL_AR;
              pc_ld   = 1'b1;
            end
            OP_ISZ: begin
              dr_inc = 1'b1;
              sc_d   = T7;
            end
            default: sc_d = T0;
          endcase
        end
        T7: begin
          // Only ISZ reaches T7; SC always returns to T0 so it never wraps
          sc_d = T0;
          if (opcode == OP_ISZ) begin
            bus_sel = SEL_DR;
            mem_wr  = 1'b1;
            pc_inc  = dr_zero;
          end
        end
        default: sc_d = T0;
      endcase
    end

    if (halted_q) sc_d = T0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sc_q     <= T0;
      halted_q <= 1'b0;
    end else begin
      sc_q     <= sc_d;
      halted_q <= halted_d;
    end
  end

  assign sc     = sc_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer
//   Directed-vector bench for control_sequencer. Each step checks sc and the
//   packed control word {bus_sel, alu_op, strobes} against hand-derived values.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] ir;
  logic       dr_zero;
  logic [2:0] bus_sel;
  logic       ar_ld, ar_inc, pc_ld, pc_inc, dr_ld, dr_inc;
  logic       ac_ld, ac_clr, ac_inc, ir_ld, mem_rd, mem_wr;
  logic [1:0] alu_op;
  logic [2:0] sc;
  logic       halted;

  control_sequencer dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .IR_DATA (ir),
    .dr_zero (dr_zero),
    .bus_sel (bus_sel),
    .ar_ld   (ar_ld),
    .ar_inc  (ar_inc),
    .pc_ld   (pc_ld),
    .pc_inc  (pc_inc),
    .dr_ld   (dr_ld),
    .dr_inc  (dr_inc),
    .ac_ld   (ac_ld),
    .ac_clr  (ac_clr),
    .ac_inc  (ac_inc),
    .alu_op  (alu_op),
    .ir_ld   (ir_ld),
    .mem_rd  (mem_rd),
    .mem_wr  (mem_wr),
    .sc      (sc),
    .halted  (halted)
  );

  always #5 clk = ~clk;

  // Strobe bit positions in the packed control word
  localparam int AR_LD  = 1 << 11;
  localparam int AR_INC = 1 << 10;
  localparam int PC_LD  = 1 << 9;
  localparam int PC_INC = 1 << 8;
  localparam int DR_LD  = 1 << 7;
  localparam int DR_INC = 1 << 6;
  localparam int AC_LD  = 1 << 5;
  localparam int AC_CLR = 1 << 4;
  localparam int AC_INC = 1 << 3;
  localparam int IR_LD  = 1 << 2;
  localparam int MEM_RD = 1 << 1;
  localparam int MEM_WR = 1 << 0;

  localparam int S_X   = 0;
  localparam int S_AR  = 1;
  localparam int S_PC  = 2;
  localparam int S_DR  = 3;
  localparam int S_AC  = 4;
  localparam int S_MEM = 7;

  int total = 0;
  int bad   = 0;

  logic [16:0] ctl_word;
  assign ctl_word = {bus_sel, alu_op, ar_ld, ar_inc, pc_ld, pc_inc, dr_ld, dr_inc,
                     ac_ld, ac_clr, ac_inc, ir_ld, mem_rd, mem_wr};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Check the current cycle (inputs already applied), then advance one clock.
  task automatic cyc(input string tag, input int esc, input int esel, input int ealu,
                     input int estr);
    logic [31:0] e;
    #1;
    e = (esel << 14) | (ealu << 12) | estr;
    check({tag, ".sc"}, {29'd0, sc}, esc);
    check({tag, ".ctl"}, {15'd0, ctl_word}, e);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string tag);
    cyc({tag, ".T0"}, 0, S_PC, 0, AR_LD);
    cyc({tag, ".T1"}, 1, S_MEM, 0, MEM_RD | IR_LD | PC_INC);
  endtask

  // Memory-reference T2..T4; T4 differs by the I bit
  task automatic addr(input string tag, input logic ind);
    cyc({tag, ".T2"}, 2, S_PC, 0, AR_LD);
    cyc({tag, ".T3"}, 3, S_MEM, 0, MEM_RD | AR_LD | PC_INC);
    if (ind) cyc({tag, ".T4"}, 4, S_MEM, 0, MEM_RD | AR_LD);
    else     cyc({tag, ".T4"}, 4, S_X, 0, 0);
  endtask

  initial begin
    reset   = 1'b1;
    enable  = 1'b1;
    ir      = 8'h78;
    dr_zero = 1'b0;
    @(posedge clk);
    #1;
    // Reset held: outputs quiet, state cleared
    cyc("rst", 0, S_X, 0, 0);
    check("rst.halted", {31'd0, halted}, 0);
    reset = 1'b0;

    // CLA
    ir = 8'h78;
    fetch("cla");
    cyc("cla.T2", 2, S_X, 0, AC_CLR);

    // CMA+INC: CMA wins over INC
    ir = 8'h76;
    fetch("cma");
    cyc("cma.T2", 2, S_X, 3, AC_LD);

    // I=1 opcode 111 is a NOP
    ir = 8'hF0;
    fetch("nop");
    cyc("nop.T2", 2, S_X, 0, 0);

    // ADD direct
    ir = 8'h10;
    fetch("add");
    addr("add", 1'b0);
    cyc("add.T5", 5, S_MEM, 0, MEM_RD | DR_LD);
    cyc("add.T6", 6, S_X, 1, AC_LD);

    // ISZ indirect, DR becomes zero
    ir = 8'hE0;
    dr_zero = 1'b1;
    fetch("isz1");
    addr("isz1", 1'b1);
    cyc("isz1.T5", 5, S_MEM, 0, MEM_RD | DR_LD);
    cyc("isz1.T6", 6, S_X, 0, DR_INC);
    cyc("isz1.T7", 7, S_DR, 0, MEM_WR | PC_INC);

    // ISZ indirect, DR nonzero: no skip
    dr_zero = 1'b0;
    fetch("isz0");
    addr("isz0", 1'b1);
    cyc("isz0.T5", 5, S_MEM, 0, MEM_RD | DR_LD);
    cyc("isz0.T6", 6, S_X, 0, DR_INC);
    cyc("isz0.T7", 7, S_DR, 0, MEM_WR);

    // BSA direct
    ir = 8'h50;
    fetch("bsa");
    addr("bsa", 1'b0);
    cyc("bsa.T5", 5, S_PC, 0, MEM_WR | AR_INC);
    cyc("bsa.T6", 6, S_AR, 0, PC_LD);

    // STA
    ir = 8'h30;
    fetch("sta");
    addr("sta", 1'b0);
    cyc("sta.T5", 5, S_AC, 0, MEM_WR);

    // BUN indirect
    ir = 8'hC0;
    fetch("bun");
    addr("bun", 1'b1);
    cyc("bun.T5", 5, S_AR, 0, PC_LD);

    // LDA direct
    ir = 8'h20;
    fetch("lda");
    addr("lda", 1'b0);
    cyc("lda.T5", 5, S_MEM, 0, MEM_RD | DR_LD);
    cyc("lda.T6", 6, S_X, 2, AC_LD);

    // ADD with enable dropped at T5 for three cycles
    ir = 8'h10;
    fetch("stall");
    addr("stall", 1'b0);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) cyc("stall.hold", 5, S_X, 0, 0);
    enable = 1'b1;
    cyc("stall.T5", 5, S_MEM, 0, MEM_RD | DR_LD);
    cyc("stall.T6", 6, S_X, 1, AC_LD);

    // Reset asserted at T3 abandons the instruction
    fetch("mrst");
    cyc("mrst.T2", 2, S_PC, 0, AR_LD);
    reset = 1'b1;
    cyc("mrst.T3", 3, S_X, 0, 0);
    reset = 1'b0;
    #1;
    check("mrst.sc", {29'd0, sc}, 0);

    // HLT
    ir = 8'h71;
    fetch("hlt");
    cyc("hlt.T2", 2, S_X, 0, 0);
    check("hlt.halted", {31'd0, halted}, 1);
    for (int i = 0; i < 3; i++) cyc("hlt.stuck", 0, S_X, 0, 0);
    enable = 1'b0;
    cyc("hlt.dis", 0, S_X, 0, 0);
    enable = 1'b1;
    cyc("hlt.en", 0, S_X, 0, 0);
    check("hlt.still", {31'd0, halted}, 1);
    reset = 1'b1;
    cyc("hlt.rst", 0, S_X, 0, 0);
    reset = 1'b0;
    check("hlt.clear", {31'd0, halted}, 0);
    ir = 8'h78;
    fetch("resume");
    cyc("resume.T2", 2, S_X, 0, AC_CLR);
    check("resume.sc", {29'd0, sc}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
